// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into big-endian instruction words,
// writes them to instruction memory and releases the CPU on a valid image.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] HDR_HI  = 3'd0;
  localparam logic [2:0] HDR_LO  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CHKSUM  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERROR   = 3'd5;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state, nxt;
  logic [15:0] cnt;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [7:0]  sum;
  logic [23:0] wreg;
  logic        xfer;
  logic        last_word;
  logic        rearm;
  logic [15:0] full_cnt;

  assign xfer      = in_valid & in_ready;
  assign last_word = (wcnt + 16'd1) == cnt;
  assign rearm     = restart & ((state == DONE) | (state == ERROR));
  assign full_cnt  = {cnt[15:8], in_data};

  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_rst_n = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      HDR_HI:
        if (xfer) nxt = HDR_LO;
      HDR_LO:
        if (xfer) begin
          if ({1'b0, full_cnt} > DEPTH_W) nxt = ERROR;
          else if (full_cnt == 16'd0)     nxt = CHKSUM;
          else                            nxt = PAYLOAD;
        end
      PAYLOAD:
        if (xfer && bcnt == 2'd3 && last_word) nxt = CHKSUM;
      CHKSUM:
        if (xfer) nxt = (in_data == sum) ? DONE : ERROR;
      DONE, ERROR:
        if (restart) nxt = HDR_HI;
      default:
        nxt = HDR_HI;
    endcase
  end

  // in_ready is registered so it stays low while reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR_HI;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'h0;
      cnt       <= 16'h0;
      wcnt      <= 16'h0;
      bcnt      <= 2'd0;
      sum       <= 8'h0;
      wreg      <= 24'h0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt <= CHKSUM);
      mem_we   <= 1'b0;
      if (xfer) begin
        case (state)
          HDR_HI: begin
            cnt[15:8] <= in_data;
            sum       <= sum + in_data;
          end
          HDR_LO: begin
            cnt[7:0] <= in_data;
            sum      <= sum + in_data;
          end
          PAYLOAD: begin
            sum  <= sum + in_data;
            bcnt <= bcnt + 2'd1;
            wreg <= {wreg[15:0], in_data};
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {wreg, in_data};
              mem_addr  <= BASE_ADDR + {14'h0, wcnt, 2'b00};
              wcnt      <= wcnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
      if (rearm) begin
        cnt  <= 16'h0;
        wcnt <= 16'h0;
        bcnt <= 2'd0;
        sum  <= 8'h0;
        wreg <= 24'h0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are streamed in, expected memory writes
// go to a scoreboard and are matched as mem_we pulses appear.
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int passed = 0;
  int total  = 0;
  int stalls = 0;
  bit due    = 1'b0;

  logic [63:0] sb[$];
  logic [7:0]  frm[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [63:0] e;
    if (due) begin
      total++;
      if (mem_we !== 1'b1)
        $display("FAIL we_latency: mem_we=%b want 1", mem_we);
      else passed++;
      due = 1'b0;
    end
    if (mem_we === 1'b1) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL unexpected_write: addr=%h data=%h want none",
                 mem_addr, mem_wdata);
      else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e)
          $display("FAIL write: addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        else passed++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input bit gap);
    int n;
    logic [31:0] w = 32'h0;
    n = {frm[0], frm[1]};
    for (int i = 0; i < frm.size(); i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      send(frm[i]);
      if (i >= 2 && n <= DEPTH && i < 2 + 4 * n) begin
        w = {w[23:0], frm[i]};
        if ((i - 2) % 4 == 3) begin
          sb.push_back({BASE + 32'(4 * ((i - 2) / 4)), w});
          due = 1'b1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_sb(input string nm);
    total++;
    if (sb.size() != 0)
      $display("FAIL %s_pending: left=%0d want 0", nm, sb.size());
    else passed++;
  endtask

  task automatic check_flags(input string nm, input logic [3:0] want);
    total++;
    if ({done, error, cpu_rst_n, in_ready} !== want)
      $display("FAIL %s: done,error,cpu_rst_n,in_ready=%b want %b",
               nm, {done, error, cpu_rst_n, in_ready}, want);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error}
        !== {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset: rdy=%b we=%b a=%h d=%h c=%b dn=%b er=%b want 0/0/%h/0/0/0/0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error, BASE);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_flags("reset_release", 4'b0001);
  endtask

  task automatic test_valid_two_word();
    frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'hF0, 8'h25,
            8'h24, 8'h1D, 8'h10, 8'h00, 8'h68};
    send_frame(1'b0);
    check_flags("valid_done", 4'b1010);
    check_sb("valid");
  endtask

  task automatic test_dropped();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i * 37);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_flags("dropped_done", 4'b1010);
  endtask

  task automatic test_restart();
    pulse_restart();
    check_flags("restart_cpu_rst", 4'b0001);
    frm = '{8'h00, 8'h01, 8'h8F, 8'h99, 8'h00, 8'h08, 8'h31};
    send_frame(1'b0);
    check_flags("restart_done", 4'b1010);
    check_sb("restart");
  endtask

  task automatic test_bad_checksum();
    pulse_restart();
    frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'hF0, 8'h25,
            8'h24, 8'h1D, 8'h10, 8'h00, 8'h69};
    send_frame(1'b0);
    check_flags("badsum_error", 4'b0100);
    check_sb("badsum");
  endtask

  task automatic test_oversize();
    pulse_restart();
    frm = '{8'h04, 8'h01};
    send_frame(1'b0);
    check_flags("oversize_error", 4'b0100);
    repeat (3) @(negedge clk);
    check_sb("oversize");
  endtask

  task automatic test_zero_length();
    pulse_restart();
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_flags("zero_done", 4'b1010);
    pulse_restart();
    frm = '{8'h00, 8'h00, 8'h01};
    send_frame(1'b0);
    check_flags("zero_badsum", 4'b0100);
    check_sb("zero");
  endtask

  task automatic test_back_to_back();
    pulse_restart();
    frm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F};
    send_frame(1'b1);
    check_flags("stall_done", 4'b1010);
    pulse_restart();
    stalls = 0;
    send_frame(1'b0);
    check_flags("b2b_done", 4'b1010);
    total++;
    if (stalls != 0)
      $display("FAIL b2b_ready: stall_cycles=%0d want 0", stalls);
    else passed++;
    check_sb("b2b");
  endtask

  task automatic test_async_reset();
    pulse_restart();
    send(8'h00);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error}
        !== {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset: rdy=%b we=%b a=%h d=%h c=%b dn=%b er=%b want 0/0/%h/0/0/0/0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error, BASE);
    else passed++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_flags("post_reset_done", 4'b1010);
    check_sb("async");
  endtask

  initial begin
    test_reset();
    test_valid_two_word();
    test_dropped();
    test_restart();
    test_bad_checksum();
    test_oversize();
    test_zero_length();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
